// File: rtl/calc1_port_responder.sv
// calc1 port target: captures cmd+op1, then op2, waits a fixed latency and
// returns a one-cycle registered response with the 32-bit result.
module calc1_port_responder #(
    parameter int LATENCY = 3
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:3]  req_cmd_in,
    input  logic [0:31] req_data_in,
    output logic [0:1]  out_resp,
    output logic [0:31] out_data,
    output logic        busy
);

    localparam int CW = $clog2(LATENCY) + 1;

    localparam logic [0:3] CMD_ADD = 4'd1;
    localparam logic [0:3] CMD_SUB = 4'd2;
    localparam logic [0:3] CMD_LSH = 4'd5;
    localparam logic [0:3] CMD_RSH = 4'd6;

    localparam logic [0:1] RESP_OK  = 2'd1;
    localparam logic [0:1] RESP_ERR = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        OP2,
        EXEC
    } state_t;

    state_t        state;
    logic [0:3]    cmd_q;
    logic [0:31]   op1_q;
    logic [0:31]   op2_q;
    logic [CW-1:0] cnt;

    logic [0:1]    resp_calc;
    logic [0:31]   data_calc;
    logic [32:0]   sum;

    // Result is computed from the latched operands; it is only sampled on the
    // final EXEC edge, so it has the whole latency window to settle.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        sum       = {1'b0, op1_q} + {1'b0, op2_q};
        resp_calc = RESP_ERR;
        data_calc = '0;
        case (cmd_q)
            CMD_ADD: begin
                if (!sum[32]) begin
                    resp_calc = RESP_OK;
                    data_calc = sum[31:0];
                end
            end
            CMD_SUB: begin
                if (op2_q <= op1_q) begin
                    resp_calc = RESP_OK;
                    data_calc = op1_q - op2_q;
                end
            end
            CMD_LSH: begin
                resp_calc = RESP_OK;
                data_calc = op1_q << op2_q[27:31];
            end
            CMD_RSH: begin
                resp_calc = RESP_OK;
                data_calc = op1_q >> op2_q[27:31];
            end
            default: ;
        endcase
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cmd_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            cnt      <= '0;
            out_resp <= '0;
            out_data <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            out_resp <= '0;
            out_data <= '0;
            case (state)
                IDLE: begin
                    if (req_cmd_in != '0) begin
                        cmd_q <= req_cmd_in;
                        op1_q <= req_data_in;
                        state <= OP2;
                    end
                end
                OP2: begin
                    op2_q <= req_data_in;
                    cnt   <= CW'(LATENCY - 1);
                    state <= EXEC;
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        out_resp <= resp_calc;
                        out_data <= data_calc;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_calc1_port_responder.sv
// Bench for calc1_port_responder: directed literal cases plus randomized
// traffic checked every cycle against a transaction-level timing model.
module tb_calc1_port_responder;

    localparam int LATENCY = 3;

    logic        c_clk;
    logic        reset;
    logic [0:3]  req_cmd_in;
    logic [0:31] req_data_in;
    logic [0:1]  out_resp;
    logic [0:31] out_data;
    logic        busy;

    calc1_port_responder #(.LATENCY(LATENCY)) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .busy        (busy)
    );

    initial begin
        c_clk = 1'b0;
        forever #5 c_clk = ~c_clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void ref_calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                     output logic [1:0] r, output logic [31:0] d);
        logic [63:0] s;
        r = 2'd2;
        d = 32'd0;
        case (c)
            4'd1: begin
                s = {32'h0, a} + {32'h0, b};
                if (s <= 64'hFFFF_FFFF) begin
                    r = 2'd1;
                    d = 32'(s);
                end
            end
            4'd2: if (a >= b) begin r = 2'd1; d = a - b; end
            4'd5: begin r = 2'd1; d = a << (b % 32); end
            4'd6: begin r = 2'd1; d = a >> (b % 32); end
            default: ;
        endcase
    endfunction

    // Transaction model: an op accepted at edge n takes op2 at n+1 and
    // responds at n+1+LATENCY; the port is busy in between.
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    logic        exp_busy;
    bit          pending;
    int          edge_no;
    int          acc_edge;
    logic [3:0]  m_cmd;
    logic [31:0] m_op1, m_op2;

    always @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            pending  = 1'b0;
            exp_resp = '0;
            exp_data = '0;
            exp_busy = 1'b0;
        end else begin
            bit was_pending;
            was_pending = pending;
            exp_resp = '0;
            exp_data = '0;
            if (pending && edge_no == acc_edge + 1)
                m_op2 = req_data_in;
            if (pending && edge_no == acc_edge + 1 + LATENCY) begin
                ref_calc(m_cmd, m_op1, m_op2, exp_resp, exp_data);
                pending = 1'b0;
            end
            if (!was_pending && req_cmd_in != 4'd0) begin
                pending  = 1'b1;
                acc_edge = edge_no;
                m_cmd    = req_cmd_in;
                m_op1    = req_data_in;
            end
            exp_busy = pending;
            edge_no++;
        end
    end

    always @(negedge c_clk) begin
        if (cmp_en) begin
            check("cyc_resp", out_resp, exp_resp);
            check("cyc_data", out_data, exp_data);
            check("cyc_busy", busy, exp_busy);
        end
    end

    task automatic step();
        @(posedge c_clk);
        #2;
    endtask

    // Issue one op from an idle port and check the literal response at k+4.
    task automatic do_op(input string name, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] er, input logic [31:0] ed);
        req_cmd_in  = c;
        req_data_in = a;
        step();
        req_cmd_in  = 4'($urandom);
        req_data_in = b;
        step();
        req_cmd_in  = 4'd0;
        req_data_in = $urandom;
        for (int i = 0; i < LATENCY; i++) step();
        check({name, "_resp"}, out_resp, er);
        check({name, "_data"}, out_data, ed);
        check({name, "_model"}, {exp_resp, exp_data}, {er, ed});
        step();
        check({name, "_clear"}, {out_resp, out_data}, 34'd0);
    endtask

    initial begin
        edge_no     = 0;
        pending     = 1'b0;
        reset       = 1'b0;
        req_cmd_in  = 4'd0;
        req_data_in = 32'd0;
        repeat (2) @(posedge c_clk);
        #2;
        check("reset_outputs", {out_resp, out_data, busy}, 35'd0);
        cmp_en = 1'b1;
        reset  = 1'b1;
        step();

        do_op("add_255_1",  4'd1, 32'd255,         32'd1,     2'd1, 32'd256);
        do_op("add_ovf",    4'd1, 32'hFFFF_FFFF,   32'd1,     2'd2, 32'd0);
        do_op("sub_5_6",    4'd2, 32'd5,           32'd6,     2'd2, 32'd0);
        do_op("sub_6_5",    4'd2, 32'd6,           32'd5,     2'd1, 32'd1);
        do_op("lsh_1_21",   4'd5, 32'd1,           32'h21,    2'd1, 32'd2);
        do_op("rsh_msb_31", 4'd6, 32'h8000_0000,   32'd31,    2'd1, 32'd1);

        // Invalid cmd, an ignored ADD while busy, then back-to-back ADD.
        req_cmd_in = 4'd3; req_data_in = 32'd7;  step();
        req_cmd_in = 4'd0; req_data_in = 32'd7;  step();
        req_cmd_in = 4'd1; req_data_in = 32'd9;  step();
        req_cmd_in = 4'd0;                       step();
        check("inv_busy", busy, 1'b1);
        step();
        check("inv_resp", {out_resp, out_data}, {2'd2, 32'd0});
        req_cmd_in = 4'd1; req_data_in = 32'd10; step();
        check("b2b_busy", busy, 1'b1);
        req_cmd_in = 4'd0; req_data_in = 32'd20; step();
        step();
        step();
        check("b2b_early", out_resp, 2'd0);
        step();
        check("b2b_resp", {out_resp, out_data}, {2'd1, 32'd30});
        step();

        // Reset in EXEC discards the op.
        req_cmd_in = 4'd1; req_data_in = 32'd100; step();
        req_cmd_in = 4'd0; req_data_in = 32'd200; step();
        step();
        reset = 1'b0;
        #1;
        check("rst_exec", {out_resp, out_data, busy}, 35'd0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rst_no_resp", {out_resp, busy}, 3'd0);
        end
        do_op("add_2_3", 4'd1, 32'd2, 32'd3, 2'd1, 32'd5);

        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 9);
            case (r)
                4:       req_cmd_in = 4'd1;
                5:       req_cmd_in = 4'd2;
                6:       req_cmd_in = 4'd5;
                7:       req_cmd_in = 4'd6;
                8:       req_cmd_in = 4'($urandom);
                9:       req_cmd_in = 4'd1;
                default: req_cmd_in = 4'd0;
            endcase
            case ($urandom_range(0, 3))
                0:       req_data_in = $urandom_range(0, 40);
                1:       req_data_in = 32'hFFFF_FFFF - $urandom_range(0, 40);
                default: req_data_in = $urandom;
            endcase
            reset = ($urandom_range(0, 299) != 0);
            step();
        end

        reset      = 1'b1;
        req_cmd_in = 4'd0;
        for (int i = 0; i < LATENCY + 3; i++) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
